commit_stage: RTL and testbench
===============================

COMMIT_STAGE -- requirements
Module: commit_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 nrst  in  1  reset, synchronous, active-low; sampled on rising clk only.
REQ-003 valid5  in  1  pipe #5 carries an instruction this cycle.
REQ-004 we5  in  1  instruction writes a destination register.
REQ-005 rd5  in  5  destination register address.
REQ-006 result5  in  32  execute-stage result; for loads, the byte address.
REQ-007 load5  in  1  instruction is a load.
REQ-008 ld_fn5  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 mem_rvalid  in  1  data memory read response valid, one-cycle pulse.
REQ-010 mem_rdata  in  32  aligned 32-bit read word.
REQ-011 we6  out  1  regfile write enable (pipe #6).
REQ-012 rdaddr6  out  5  regfile write address.
REQ-013 wb6  out  32  regfile write data.
REQ-014 stall  out  1  upstream holds pipe #5 while high.
REQ-015 mem_err  out  1  sticky load-timeout flag.
REQ-016 instret  out  32  retired-instruction counter.

Function
REQ-017 The FSM SHALL have states IDLE and WAIT_LD.
REQ-018 In IDLE, valid5=1 with load5=0 SHALL register the instruction into pipe #6.
- Next cycle: we6 = we5 & (rd5!=0), rdaddr6 = rd5, wb6 = result5.
REQ-019 In IDLE, valid5=1 with load5=1 SHALL capture rd5, we5, ld_fn5 and result5[1:0], then enter WAIT_LD.
- Next cycle: we6=0.
REQ-020 In every cycle not covered by REQ-018 or REQ-023, we6 SHALL be 0.
- rdaddr6 and wb6 hold their last values.
REQ-021 stall SHALL equal (state==WAIT_LD).
- Upstream presents the held instruction again; valid5 is ignored in WAIT_LD.
REQ-022 The byte lane for load data SHALL be chosen by the captured addr[1:0].
- LB/LBU: byte addr[1:0].
- LH/LHU: halfword addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend.
- LW and undefined funct3 pass the full word.
REQ-023 In WAIT_LD, mem_rvalid=1 SHALL return the FSM to IDLE.
- Next cycle: we6 = captured we & (rd!=0), rdaddr6 = captured rd, wb6 = extracted data.
REQ-024 mem_rvalid in IDLE SHALL be ignored (no write, no state change).
REQ-025 A 4-bit wait counter SHALL clear on entry to WAIT_LD and increment each WAIT_LD cycle without mem_rvalid.
REQ-026 When the wait counter reaches 15 without mem_rvalid, the block SHALL return to IDLE with no write and set mem_err=1.
- mem_err stays 1 until reset.
- mem_rvalid arriving in the same cycle as the count of 15 wins: normal completion, no error.
REQ-027 instret SHALL increment by 1, once per retired instruction, in the cycle its pipe #6 values appear.
- Retired = non-load accepted in IDLE, or load completed per REQ-023.
- Includes rd=0 and we=0 instructions.
- Excludes timed-out loads.
- Wraps 0xFFFFFFFF -> 0.
REQ-028 Latency SHALL be 1 cycle for non-loads.
- For loads: 1 cycle after the mem_rvalid cycle; minimum 2 cycles after acceptance.

Reset
REQ-029 With nrst=0 at a rising edge, the block SHALL load:
- state=IDLE, counter=0, we6=0, rdaddr6=0, wb6=0, mem_err=0, instret=0, stall=0.
REQ-030 Reset in WAIT_LD SHALL abandon the load with no write.
- A mem_rvalid arriving after reset is ignored per REQ-024.
REQ-031 Asserting nrst between clock edges SHALL have no effect until the next rising edge.

Verification
REQ-032 ALU op: valid5=1, we5=1, rd5=5, result5=0x1234 -> next cycle we6=1, rdaddr6=5, wb6=0x1234, instret=1.
REQ-033 LB with addr[1:0]=3, mem_rvalid 3 cycles later with rdata=0x80FF_0000:
- stall=1 for 3 cycles.
- Then we6=1, wb6=0xFFFFFF80.
- Repeat with LBU -> wb6=0x00000080.
REQ-034 LH with addr[1]=1, rdata=0x8001_7FFF -> wb6=0xFFFF8001; LHU -> wb6=0x00008001.
REQ-035 rd5=0 ALU op -> we6=0, instret increments; mem_rvalid while IDLE -> no write, no state change.
REQ-036 Load with no mem_rvalid:
- stall high 15 cycles, then drops.
- mem_err=1, no write, instret unchanged.
- Repeat with rvalid on cycle 15 -> normal write, mem_err=0.
REQ-037 nrst=0 while in WAIT_LD -> next cycle all outputs at reset values; a later mem_rvalid causes no write.

Source files
------------

// File: rtl/commit_stage.sv
// Commit stage: retires ALU results straight into the regfile write port and
// holds loads until the data memory answers, extracting and extending the
// addressed byte/halfword. A load that gets no answer within 15 wait cycles
// is dropped and flagged on a sticky error bit.
//
// Ports:
//   clk, nrst           clock, synchronous active-low reset
//   valid5, we5, rd5    pipe #5 instruction valid, write enable, destination
//   result5             ALU result, or byte address for loads
//   load5, ld_fn5       load marker and load funct3
//   mem_rvalid          one-cycle read response strobe
//   mem_rdata           aligned 32-bit read word
//   we6, rdaddr6, wb6   regfile write port (pipe #6)
//   stall               upstream holds pipe #5 while a load is outstanding
//   mem_err             sticky load-timeout flag
//   instret             retired-instruction counter
module commit_stage (
   input  logic        clk,
   input  logic        nrst,
   input  logic        valid5,
   input  logic        we5,
   input  logic [4:0]  rd5,
   input  logic [31:0] result5,
   input  logic        load5,
   input  logic [2:0]  ld_fn5,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        we6,
   output logic [4:0]  rdaddr6,
   output logic [31:0] wb6,
   output logic        stall,
   output logic        mem_err,
   output logic [31:0] instret
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned FW   = 3;
   localparam int unsigned CW   = 4;

   // Last wait count before timeout: 15 WAIT_LD cycles in total.
   localparam logic [CW-1:0] WAIT_LAST = CW'(14);

   localparam logic [FW-1:0] FN_LB  = 3'b000;
   localparam logic [FW-1:0] FN_LH  = 3'b001;
   localparam logic [FW-1:0] FN_LBU = 3'b100;
   localparam logic [FW-1:0] FN_LHU = 3'b101;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_LD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Captured load context
   logic [RW-1:0]   ld_rd_q;
   logic            ld_we_q;
   logic [FW-1:0]   ld_fn_q;
   logic [1:0]      ld_off_q;
   logic            capture;

   logic            we6_d;
   logic [RW-1:0]   rdaddr6_d;
   logic [XLEN-1:0] wb6_d;
   logic            mem_err_d;
   logic            retire;

   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;

   // Byte/halfword lane selection and sign/zero extension of the read word
   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (ld_off_q)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_fn_q)
         FN_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         FN_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         FN_LBU:  ld_data = {24'd0, ld_byte};
         FN_LHU:  ld_data = {16'd0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture   = 1'b0;
      we6_d     = 1'b0;
      rdaddr6_d = rdaddr6;
      wb6_d     = wb6;
      mem_err_d = mem_err;
      retire    = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid5) begin
               if (load5) begin
                  capture = 1'b1;
                  cnt_d   = '0;
                  state_d = WAIT_LD;
               end else begin
                  we6_d     = we5 && (rd5 != '0);
                  rdaddr6_d = rd5;
                  wb6_d     = result5;
                  retire    = 1'b1;
               end
            end
         end
         WAIT_LD: begin
            // A response in the final wait cycle still completes normally
            if (mem_rvalid) begin
               we6_d     = ld_we_q && (ld_rd_q != '0);
               rdaddr6_d = ld_rd_q;
               wb6_d     = ld_data;
               retire    = 1'b1;
               state_d   = IDLE;
            end else if (cnt_q == WAIT_LAST) begin
               mem_err_d = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output and load-context registers
   always_ff @(posedge clk) begin
      if (!nrst) begin
         ld_rd_q  <= '0;
         ld_we_q  <= 1'b0;
         ld_fn_q  <= '0;
         ld_off_q <= '0;
         we6      <= 1'b0;
         rdaddr6  <= '0;
         wb6      <= '0;
         stall    <= 1'b0;
         mem_err  <= 1'b0;
         instret  <= '0;
      end else begin
         if (capture) begin
            ld_rd_q  <= rd5;
            ld_we_q  <= we5;
            ld_fn_q  <= ld_fn5;
            ld_off_q <= result5[1:0];
         end
         we6     <= we6_d;
         rdaddr6 <= rdaddr6_d;
         wb6     <= wb6_d;
         stall   <= (state_d == WAIT_LD);
         mem_err <= mem_err_d;
         instret <= instret + XLEN'(retire);
      end
   end

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage.
module tb_commit_stage;

   logic        clk = 1'b0;
   logic        nrst;
   logic        valid5, we5, load5, mem_rvalid;
   logic [4:0]  rd5;
   logic [31:0] result5, mem_rdata;
   logic [2:0]  ld_fn5;
   logic        we6, stall, mem_err;
   logic [4:0]  rdaddr6;
   logic [31:0] wb6, instret;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_ret;

   commit_stage dut (
      .clk(clk), .nrst(nrst), .valid5(valid5), .we5(we5), .rd5(rd5),
      .result5(result5), .load5(load5), .ld_fn5(ld_fn5),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .we6(we6), .rdaddr6(rdaddr6), .wb6(wb6), .stall(stall),
      .mem_err(mem_err), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " we6"}, 32'(we6), 32'd0);
      check({tag, " rdaddr6"}, 32'(rdaddr6), 32'd0);
      check({tag, " wb6"}, wb6, 32'd0);
      check({tag, " stall"}, 32'(stall), 32'd0);
      check({tag, " mem_err"}, 32'(mem_err), 32'd0);
      check({tag, " instret"}, instret, 32'd0);
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      exp_ret = '0;
   endtask

   task automatic alu_op(input logic we, input logic [4:0] rd, input logic [31:0] res);
      valid5 = 1'b1; load5 = 1'b0; we5 = we; rd5 = rd; result5 = res;
      step();
      valid5 = 1'b0;
   endtask

   // Issue a load; response arrives in the lat-th WAIT_LD cycle.
   task automatic load_op(input string tag, input logic [2:0] fn, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata, input int lat);
      valid5 = 1'b1; load5 = 1'b1; we5 = 1'b1; rd5 = rd; ld_fn5 = fn; result5 = addr;
      step();
      // Upstream keeps re-presenting the held load; it must be ignored.
      for (int i = 1; i < lat; i++) begin
         check({tag, " stall"}, 32'(stall), 32'd1);
         check({tag, " we6 wait"}, 32'(we6), 32'd0);
         step();
      end
      check({tag, " stall last"}, 32'(stall), 32'd1);
      valid5 = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0;
      exp_ret = exp_ret + 32'd1;
      check({tag, " stall drop"}, 32'(stall), 32'd0);
      check({tag, " we6"}, 32'(we6), 32'd1);
      check({tag, " rdaddr6"}, 32'(rdaddr6), 32'(rd));
      check({tag, " instret"}, instret, exp_ret);
   endtask

   initial begin
      nrst = 1'b0; valid5 = 1'b0; we5 = 1'b0; rd5 = '0; result5 = '0;
      load5 = 1'b0; ld_fn5 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
      step();
      step();
      check_reset_vals("reset");
      nrst = 1'b1;
      exp_ret = '0;

      // ALU op
      alu_op(1'b1, 5'd5, 32'h0000_1234);
      exp_ret = exp_ret + 32'd1;
      check("alu we6", 32'(we6), 32'd1);
      check("alu rdaddr6", 32'(rdaddr6), 32'd5);
      check("alu wb6", wb6, 32'h0000_1234);
      check("alu instret", instret, 32'd1);
      step();
      check("idle we6", 32'(we6), 32'd0);
      check("idle wb6 hold", wb6, 32'h0000_1234);
      check("idle rdaddr6 hold", 32'(rdaddr6), 32'd5);

      // Loads with lane selection and extension
      load_op("lb3", 3'b000, 32'h0000_1003, 5'd7, 32'h80FF_0000, 3);
      check("lb3 wb6", wb6, 32'hFFFF_FF80);
      load_op("lbu3", 3'b100, 32'h0000_1003, 5'd8, 32'h80FF_0000, 3);
      check("lbu3 wb6", wb6, 32'h0000_0080);
      load_op("lh2", 3'b001, 32'h0000_2002, 5'd9, 32'h8001_7FFF, 1);
      check("lh2 wb6", wb6, 32'hFFFF_8001);
      load_op("lhu2", 3'b101, 32'h0000_2002, 5'd10, 32'h8001_7FFF, 2);
      check("lhu2 wb6", wb6, 32'h0000_8001);
      load_op("lh0", 3'b001, 32'h0000_2000, 5'd11, 32'h8001_7FFF, 1);
      check("lh0 wb6", wb6, 32'h0000_7FFF);
      load_op("lb1", 3'b000, 32'h0000_3001, 5'd12, 32'h80FF_7F00, 1);
      check("lb1 wb6", wb6, 32'h0000_007F);
      load_op("lb2", 3'b000, 32'h0000_3002, 5'd12, 32'h80FE_7F00, 1);
      check("lb2 wb6", wb6, 32'hFFFF_FFFE);
      load_op("lw", 3'b010, 32'h0000_4000, 5'd13, 32'hDEAD_BEEF, 2);
      check("lw wb6", wb6, 32'hDEAD_BEEF);
      load_op("fn3", 3'b011, 32'h0000_4001, 5'd14, 32'hCAFE_F00D, 1);
      check("fn3 wb6", wb6, 32'hCAFE_F00D);
      step();

      // rd=0 ALU op retires without a write
      alu_op(1'b1, 5'd0, 32'h5555_AAAA);
      exp_ret = exp_ret + 32'd1;
      check("rd0 we6", 32'(we6), 32'd0);
      check("rd0 instret", instret, exp_ret);
      alu_op(1'b0, 5'd3, 32'h0000_0077);
      exp_ret = exp_ret + 32'd1;
      check("we0 we6", 32'(we6), 32'd0);
      check("we0 instret", instret, exp_ret);

      // Stray response while idle
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      step();
      mem_rvalid = 1'b0;
      check("idle rvalid we6", 32'(we6), 32'd0);
      check("idle rvalid stall", 32'(stall), 32'd0);
      check("idle rvalid instret", instret, exp_ret);

      // Load with no response: 15 stall cycles then timeout
      valid5 = 1'b1; load5 = 1'b1; we5 = 1'b1; rd5 = 5'd6; ld_fn5 = 3'b010; result5 = 32'h100;
      step();
      valid5 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         check($sformatf("to stall %0d", i + 1), 32'(stall), 32'd1);
         check("to we6 wait", 32'(we6), 32'd0);
         step();
      end
      check("to stall drop", 32'(stall), 32'd0);
      check("to mem_err", 32'(mem_err), 32'd1);
      check("to we6", 32'(we6), 32'd0);
      check("to instret", instret, exp_ret);
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      check("to late rvalid we6", 32'(we6), 32'd0);
      alu_op(1'b1, 5'd2, 32'h0000_0002);
      exp_ret = exp_ret + 32'd1;
      check("to sticky mem_err", 32'(mem_err), 32'd1);
      check("to alu instret", instret, exp_ret);

      // Reset clears the flag; response in the 15th cycle wins
      do_reset();
      check_reset_vals("reset2");
      load_op("rv15", 3'b010, 32'h0000_0200, 5'd4, 32'h0BAD_F00D, 15);
      check("rv15 wb6", wb6, 32'h0BAD_F00D);
      check("rv15 mem_err", 32'(mem_err), 32'd0);

      // Reset pulse between edges has no effect
      step();
      #2 nrst = 1'b0;
      #2 nrst = 1'b1;
      step();
      check("glitch instret", instret, exp_ret);
      check("glitch wb6", wb6, 32'h0BAD_F00D);

      // Reset while waiting abandons the load
      valid5 = 1'b1; load5 = 1'b1; we5 = 1'b1; rd5 = 5'd9; ld_fn5 = 3'b010; result5 = 32'h300;
      step();
      valid5 = 1'b0;
      check("rstw stall", 32'(stall), 32'd1);
      do_reset();
      check_reset_vals("rstw");
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      mem_rvalid = 1'b0;
      check("rstw late we6", 32'(we6), 32'd0);
      check("rstw late instret", instret, 32'd0);
      check("rstw late stall", 32'(stall), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
